// File: rtl/update_wr_scheduler.sv
// Write-back scheduler for packed scatter update lines: per-bin DRAM addressing, line FIFO,
// valid/ready write port and phase framing. Define BIN_CNT_RD_EN to add the per-bin line-count read port.
module update_wr_scheduler #(
  parameter int PAR_NUM      = 16,
  parameter int PAR_NUM_W    = 4,
  parameter int PAR_LINES_W  = 20,
  parameter int ADDR_W       = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_DEPTH_W = 3,
  parameter int STALL_TH     = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      cfg_base_addr,
  input  logic                   phase_start,
  input  logic                   phase_done,
  input  logic [511:0]           line_in,
  input  logic [PAR_NUM_W-1:0]   line_in_bin,
  input  logic                   line_in_valid,
  output logic                   stall_request,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [511:0]           wr_data,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err_overflow
`ifdef BIN_CNT_RD_EN
  ,
  input  logic [PAR_NUM_W-1:0]   cnt_rd_bin,
  output logic [PAR_LINES_W:0]   cnt_rd_lines
`endif
);

  localparam int OFF_W = PAR_NUM_W + PAR_LINES_W + 6;
  localparam logic [FIFO_DEPTH_W:0] DEPTH_C = (FIFO_DEPTH_W+1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_W:0] STALL_C = (FIFO_DEPTH_W+1)'(STALL_TH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q;
  logic [PAR_LINES_W:0]    ptr_q [PAR_NUM];
  logic [ADDR_W-1:0]       fifo_addr [FIFO_DEPTH];
  logic [511:0]            fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH_W-1:0] wptr_q, rptr_q;
  logic [FIFO_DEPTH_W:0]   count_q, count_d;

  logic                    phase_go, enq, deq, load, bin_full, fifo_full;
  logic [PAR_LINES_W:0]    cur_ptr;
  logic [OFF_W-1:0]        offset;
  logic [ADDR_W-1:0]       enq_addr;

  assign phase_go  = phase_start && (state_q == S_IDLE || state_q == S_DONE);
  assign cur_ptr   = ptr_q[line_in_bin];
  assign bin_full  = cur_ptr[PAR_LINES_W];
  assign fifo_full = (count_q == DEPTH_C);
  assign enq       = line_in_valid && (state_q == S_RUN) && !bin_full && !fifo_full;
  assign offset    = {line_in_bin, cur_ptr[PAR_LINES_W-1:0], 6'b0};
  assign enq_addr  = base_q + ADDR_W'(offset);
  assign load      = !wr_valid || wr_ready;
  assign deq       = load && (count_q != '0);
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + (FIFO_DEPTH_W+1)'(1);
      2'b01:   count_d = count_q - (FIFO_DEPTH_W+1)'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      S_IDLE:  if (phase_start) state_d = S_RUN;
      S_RUN:   if (phase_done) state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0 && !wr_valid) state_d = S_DONE;
      S_DONE:  if (phase_start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      stall_request <= 1'b0;
      err_overflow  <= 1'b0;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      for (int i = 0; i < PAR_NUM; i++) ptr_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      stall_request <= (count_d >= STALL_C);
      if (phase_go) begin
        base_q <= cfg_base_addr;
        for (int i = 0; i < PAR_NUM; i++) ptr_q[i] <= '0;
      end else if (enq) begin
        ptr_q[line_in_bin] <= cur_ptr + (PAR_LINES_W+1)'(1);
      end
      // A dropped line in the same cycle as a phase start still flags the loss.
      if (line_in_valid && !enq) err_overflow <= 1'b1;
      else if (phase_go)         err_overflow <= 1'b0;
      if (enq) wptr_q <= wptr_q + FIFO_DEPTH_W'(1);
      if (deq) rptr_q <= rptr_q + FIFO_DEPTH_W'(1);
      if (load) begin
        wr_valid <= (count_q != '0);
        if (deq) begin
          wr_addr <= fifo_addr[rptr_q];
          wr_data <= fifo_data[rptr_q];
        end
      end
    end
  end

  // NOTE: line storage has no reset; occupancy and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[wptr_q] <= enq_addr;
      fifo_data[wptr_q] <= line_in;
    end
  end

`ifdef BIN_CNT_RD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_rd_lines <= '0;
    else        cnt_rd_lines <= ptr_q[cnt_rd_bin];
  end
`endif

endmodule
